reprodutor_sequencia: RTL and testbench

//  Playback scheduler for the note ROM: on request from the game control unit, walks ROM addresses 0..limite,

---
 rtl/reprodutor_sequencia_pkg.sv | 32 +++
 rtl/reprodutor_sequencia_if.sv | 26 ++
 rtl/reprodutor_sequencia_temporizador_nota.sv | 23 ++
 rtl/reprodutor_sequencia.sv | 124 ++++++++++++
 tb/tb_reprodutor_sequencia.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/reprodutor_sequencia_pkg.sv
// Shared definitions for the note playback scheduler: FSM state codes,
// the silence code and the one-hot button word to note code decoder.
package reprodutor_sequencia_pkg;

  // FSM state encoding (3 bits)
  localparam logic [2:0] OCIOSO = 3'd0;
  localparam logic [2:0] LE_MEM = 3'd1;
  localparam logic [2:0] TOCA   = 3'd2;
  localparam logic [2:0] PAUSA  = 3'd3;
  localparam logic [2:0] FIM    = 3'd4;

  // Note code driven while no note sounds
  localparam logic [2:0] NOTA_SILENCIO = 3'd0;

  // Returns {valid, code}: a word with exactly one bit k set maps to code k+1;
  // an empty or multi-hot word is invalid and maps to silence.
  function automatic logic [3:0] onehot7_para_codigo(input logic [6:0] palavra);
    logic [2:0]  codigo;
    int unsigned n_bits;
    codigo = NOTA_SILENCIO;
    n_bits = 0;
    for (int k = 0; k < 7; k++) begin
      if (palavra[k]) begin
        n_bits = n_bits + 1;
        codigo = 3'(k + 1);
      end
    end
    if (n_bits == 1) return {1'b1, codigo};
    return {1'b0, NOTA_SILENCIO};
  endfunction

endpackage

// File: rtl/reprodutor_sequencia_if.sv
// Bundle of the control, ROM and Arduino-side signals of the playback scheduler.
// master = game control / ROM / Arduino side, slave = the scheduler itself.
interface reprodutor_sequencia_if #(
  parameter int ADDR_W = 4,
  parameter int NOTE_W = 7
);
  logic              iniciar;
  logic              abortar;
  logic [ADDR_W-1:0] limite;
  logic [ADDR_W-1:0] mem_addr;
  logic [NOTE_W-1:0] mem_data;
  logic [2:0]        arduino_out;
  logic              tocando;
  logic              fim;
  logic              erro_memoria;

  modport master (
    output iniciar, abortar, limite, mem_data,
    input  mem_addr, arduino_out, tocando, fim, erro_memoria
  );

  modport slave (
    input  iniciar, abortar, limite, mem_data,
    output mem_addr, arduino_out, tocando, fim, erro_memoria
  );
endinterface

// File: rtl/reprodutor_sequencia_temporizador_nota.sv
// Up-counter shared by the note-on and gap phases. terminal_o flags the cycle
// in which the count equals the runtime limit selected by the FSM.
module temporizador_nota #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             limpa_i,
  input  logic             habilita_i,
  input  logic [CNT_W-1:0] limite_i,
  output logic             terminal_o
);
  logic [CNT_W-1:0] contagem_q;

  // Clear has priority over counting so a phase change always restarts at zero
  always_ff @(posedge clock or posedge reset) begin
    if (reset)           contagem_q <= '0;
    else if (limpa_i)    contagem_q <= '0;
    else if (habilita_i) contagem_q <= contagem_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  assign terminal_o = (contagem_q == limite_i);
endmodule

// File: rtl/reprodutor_sequencia.sv
// Playback scheduler: walks ROM addresses 0..limite, turns each one-hot word
// into a note code held for ON_CYCLES, then GAP_CYCLES of silence, then pulses fim.
module reprodutor_sequencia
  import reprodutor_sequencia_pkg::*;
#(
  parameter int ADDR_W     = 4,
  parameter int NOTE_W     = 7,
  parameter int ON_CYCLES  = 100,
  parameter int GAP_CYCLES = 20,
  parameter int CNT_W      = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  reprodutor_sequencia_if.slave bus
);
  localparam logic [CNT_W-1:0] FIM_ON  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] FIM_GAP = CNT_W'(GAP_CYCLES - 1);

  logic [2:0]        estado_q, estado_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] limite_q, limite_d;
  logic [2:0]        nota_q, nota_d;
  logic              fim_q, fim_d;
  logic              erro_q, erro_d;
  logic              t_limpa, t_habilita, t_terminal;
  logic [CNT_W-1:0]  t_limite;
  logic [3:0]        decodificado;

  assign decodificado = onehot7_para_codigo(7'(bus.mem_data));
  assign t_limite     = (estado_q == TOCA) ? FIM_ON : FIM_GAP;

  temporizador_nota #(.CNT_W(CNT_W)) u_temporizador (
    .clock      (clock),
    .reset      (reset),
    .limpa_i    (t_limpa),
    .habilita_i (t_habilita),
    .limite_i   (t_limite),
    .terminal_o (t_terminal)
  );

  // Next-state logic: abort overrides every state, fim is high only in FIM
  always_comb begin
    estado_d   = estado_q;
    addr_d     = addr_q;
    limite_d   = limite_q;
    nota_d     = nota_q;
    fim_d      = 1'b0;
    erro_d     = erro_q;
    t_limpa    = 1'b0;
    t_habilita = 1'b0;
    if (bus.abortar) begin
      estado_d = OCIOSO;
      nota_d   = NOTA_SILENCIO;
      t_limpa  = 1'b1;
    end else begin
      case (estado_q)
        OCIOSO: begin
          if (bus.iniciar) begin
            addr_d   = '0;
            limite_d = bus.limite;
            erro_d   = 1'b0;
            estado_d = LE_MEM;
          end
        end
        LE_MEM: begin
          nota_d   = decodificado[2:0];
          if (!decodificado[3]) erro_d = 1'b1;
          t_limpa  = 1'b1;
          estado_d = TOCA;
        end
        TOCA: begin
          if (t_terminal) begin
            nota_d   = NOTA_SILENCIO;
            t_limpa  = 1'b1;
            estado_d = PAUSA;
          end else begin
            t_habilita = 1'b1;
          end
        end
        PAUSA: begin
          if (t_terminal) begin
            t_limpa = 1'b1;
            if (addr_q == limite_q) begin
              estado_d = FIM;
              fim_d    = 1'b1;
            end else begin
              addr_d   = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
              estado_d = LE_MEM;
            end
          end else begin
            t_habilita = 1'b1;
          end
        end
        FIM:     estado_d = OCIOSO;
        default: estado_d = OCIOSO;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q <= OCIOSO;
      addr_q   <= '0;
      limite_q <= '0;
      nota_q   <= NOTA_SILENCIO;
      fim_q    <= 1'b0;
      erro_q   <= 1'b0;
    end else begin
      estado_q <= estado_d;
      addr_q   <= addr_d;
      limite_q <= limite_d;
      nota_q   <= nota_d;
      fim_q    <= fim_d;
      erro_q   <= erro_d;
    end
  end

  assign bus.mem_addr     = addr_q;
  assign bus.arduino_out  = nota_q;
  assign bus.fim          = fim_q;
  assign bus.erro_memoria = erro_q;
  assign bus.tocando      = (estado_q != OCIOSO);
endmodule

// File: tb/tb_reprodutor_sequencia.sv
// Self-checking bench for reprodutor_sequencia with ON_CYCLES=4, GAP_CYCLES=2.
module tb_reprodutor_sequencia;
  localparam int ON  = 4;
  localparam int GAP = 2;
  localparam int P   = 1 + ON + GAP;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  reprodutor_sequencia_if #(.ADDR_W(4), .NOTE_W(7)) bus ();

  logic [6:0] rom [16];
  assign bus.mem_data = rom[bus.mem_addr];

  reprodutor_sequencia #(
    .ADDR_W(4), .NOTE_W(7), .ON_CYCLES(ON), .GAP_CYCLES(GAP), .CNT_W(16)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_comp = 0;
  int n_err  = 0;

  logic [2:0] obs_ard [0:127];
  logic       obs_fim [0:127];
  logic       obs_toc [0:127];

  // Reference: a one-hot word plays note (bit index + 1); anything else is silent
  function automatic logic [2:0] modelo_codigo(input logic [6:0] w);
    if ($countones(w) == 1) return 3'($clog2(w) + 1);
    return 3'd0;
  endfunction

  // Reference: expected arduino_out in cycle c after the edge that sampled iniciar
  function automatic logic [2:0] nota_esperada(input int lim, input int c);
    int j, i, r;
    j = c - 1; i = j / P; r = j % P;
    if (c >= 1 && i <= lim && r >= 1 && r <= ON) return modelo_codigo(rom[i]);
    return 3'd0;
  endfunction

  function automatic logic erro_esperado(input int lim);
    for (int k = 0; k <= lim; k++) if ($countones(rom[k]) != 1) return 1'b1;
    return 1'b0;
  endfunction

  // Pulse iniciar for one cycle and record outputs for the following cycles;
  // optionally re-pulse iniciar with limite=5 at cycle 'perturba'.
  task automatic disparar(input logic [3:0] lim, input int ciclos, input int perturba);
    @(negedge clock);
    bus.limite  = lim;
    bus.iniciar = 1'b1;
    for (int c = 1; c <= ciclos; c++) begin
      @(negedge clock);
      if (c == 1) bus.iniciar = 1'b0;
      if (c == perturba) begin
        bus.iniciar = 1'b1; bus.limite = 4'd5;
      end else if (perturba > 0 && c == perturba + 1) begin
        bus.iniciar = 1'b0; bus.limite = lim;
      end
      obs_ard[c] = bus.arduino_out;
      obs_fim[c] = bus.fim;
      obs_toc[c] = bus.tocando;
    end
  endtask

  task automatic rom_exemplo();
    for (int k = 0; k < 16; k++) rom[k] = 7'b0000001;
    rom[0] = 7'b0100000; rom[1] = 7'b0000010; rom[2] = 7'b0001000;
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.iniciar = 1'b0; bus.abortar = 1'b0; bus.limite = 4'd0;
    repeat (3) @(negedge clock);
    n_comp++;
    if ({bus.arduino_out, bus.fim, bus.tocando, bus.erro_memoria, bus.mem_addr} !== 10'd0) begin
      n_err++;
      $display("FAIL reset_estado: obtido %b esperado 0", {bus.arduino_out, bus.fim, bus.tocando, bus.erro_memoria, bus.mem_addr});
    end
    reset = 1'b0;
    repeat (2) @(negedge clock);
    n_comp++;
    if (bus.tocando !== 1'b0) begin
      n_err++; $display("FAIL reset_ocioso: tocando obtido %b esperado 0", bus.tocando);
    end
    $display("test_reset done");
  endtask

  task automatic test_sequencia_basica();
    int f;
    rom_exemplo();
    f = 3 * P + 1;
    disparar(4'd2, f + 2, -1);
    for (int c = 1; c <= f + 2; c++) begin
      n_comp++;
      if (obs_ard[c] !== nota_esperada(2, c) || obs_fim[c] !== (c == f) || obs_toc[c] !== (c <= f)) begin
        n_err++;
        $display("FAIL basica ciclo %0d: obtido ard=%0d fim=%b toc=%b esperado ard=%0d fim=%b toc=%b",
                 c, obs_ard[c], obs_fim[c], obs_toc[c], nota_esperada(2, c), c == f, c <= f);
      end
    end
    $display("test_sequencia_basica limite=2 fim_ciclo=%0d done", f);
  endtask

  task automatic test_limites();
    int f;
    rom_exemplo();
    f = P + 1;
    disparar(4'd0, f + 1, -1);
    for (int c = 1; c <= f + 1; c++) begin
      n_comp++;
      if (obs_ard[c] !== nota_esperada(0, c) || obs_fim[c] !== (c == f)) begin
        n_err++;
        $display("FAIL limite0 ciclo %0d: obtido ard=%0d fim=%b esperado ard=%0d fim=%b",
                 c, obs_ard[c], obs_fim[c], nota_esperada(0, c), c == f);
      end
    end
    for (int k = 0; k < 16; k++) rom[k] = 7'(1 << $urandom_range(0, 6));
    f = 16 * P + 1;
    disparar(4'd15, f + 1, -1);
    for (int c = 1; c <= f + 1; c++) begin
      n_comp++;
      if (obs_ard[c] !== nota_esperada(15, c) || obs_fim[c] !== (c == f)) begin
        n_err++;
        $display("FAIL limite15 ciclo %0d: obtido ard=%0d fim=%b esperado ard=%0d fim=%b",
                 c, obs_ard[c], obs_fim[c], nota_esperada(15, c), c == f);
      end
    end
    repeat (3) @(negedge clock);
    n_comp++;
    if (bus.mem_addr !== 4'd15) begin
      n_err++; $display("FAIL limite15_addr: obtido %0d esperado 15", bus.mem_addr);
    end
    $display("test_limites done");
  endtask

  task automatic test_erro_memoria();
    int f;
    rom_exemplo();
    rom[1] = 7'b0000000; rom[2] = 7'b0000011;
    f = 3 * P + 1;
    disparar(4'd2, f + 1, -1);
    for (int c = 1; c <= f + 1; c++) begin
      n_comp++;
      if (obs_ard[c] !== nota_esperada(2, c)) begin
        n_err++;
        $display("FAIL erro_traco ciclo %0d: obtido %0d esperado %0d", c, obs_ard[c], nota_esperada(2, c));
      end
    end
    n_comp++;
    if (bus.erro_memoria !== 1'b1) begin
      n_err++; $display("FAIL erro_pegajoso: obtido %b esperado 1", bus.erro_memoria);
    end
    disparar(4'd0, 1, -1);
    n_comp++;
    if (bus.erro_memoria !== 1'b0) begin
      n_err++; $display("FAIL erro_limpo: obtido %b esperado 0", bus.erro_memoria);
    end
    repeat (P + 2) @(negedge clock);
    $display("test_erro_memoria done");
  endtask

  task automatic test_abortar();
    int f;
    logic viu_fim;
    rom_exemplo();
    @(negedge clock); bus.limite = 4'd2; bus.iniciar = 1'b1;
    @(negedge clock); bus.iniciar = 1'b0;
    repeat (9) @(negedge clock);
    n_comp++;
    if (bus.arduino_out !== 3'd2) begin
      n_err++; $display("FAIL abortar_pre: obtido %0d esperado 2", bus.arduino_out);
    end
    bus.abortar = 1'b1;
    @(negedge clock);
    bus.abortar = 1'b0;
    n_comp++;
    if (bus.arduino_out !== 3'd0 || bus.tocando !== 1'b0) begin
      n_err++; $display("FAIL abortar_pos: obtido ard=%0d toc=%b esperado 0 0", bus.arduino_out, bus.tocando);
    end
    viu_fim = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clock);
      if (bus.fim === 1'b1 || bus.tocando === 1'b1) viu_fim = 1'b1;
    end
    n_comp++;
    if (viu_fim !== 1'b0) begin
      n_err++; $display("FAIL abortar_sem_fim: obtido %b esperado 0", viu_fim);
    end
    f = 3 * P + 1;
    disparar(4'd2, f + 1, -1);
    for (int c = 1; c <= f + 1; c++) begin
      n_comp++;
      if (obs_ard[c] !== nota_esperada(2, c) || obs_fim[c] !== (c == f)) begin
        n_err++;
        $display("FAIL abortar_replay ciclo %0d: obtido ard=%0d fim=%b esperado ard=%0d fim=%b",
                 c, obs_ard[c], obs_fim[c], nota_esperada(2, c), c == f);
      end
    end
    $display("test_abortar done");
  endtask

  task automatic test_iniciar_ignorado();
    int f;
    rom_exemplo();
    f = 3 * P + 1;
    disparar(4'd2, f + 3, 5);
    for (int c = 1; c <= f + 3; c++) begin
      n_comp++;
      if (obs_ard[c] !== nota_esperada(2, c) || obs_fim[c] !== (c == f) || obs_toc[c] !== (c <= f)) begin
        n_err++;
        $display("FAIL ignorado ciclo %0d: obtido ard=%0d fim=%b toc=%b esperado ard=%0d fim=%b toc=%b",
                 c, obs_ard[c], obs_fim[c], obs_toc[c], nota_esperada(2, c), c == f, c <= f);
      end
    end
    $display("test_iniciar_ignorado done");
  endtask

  task automatic test_reset_assincrono();
    logic ativo;
    rom_exemplo();
    disparar(4'd2, 3, -1);
    n_comp++;
    if (bus.arduino_out !== 3'd6) begin
      n_err++; $display("FAIL rst_async_pre: obtido %0d esperado 6", bus.arduino_out);
    end
    #2 reset = 1'b1;
    #1;
    n_comp++;
    if (bus.arduino_out !== 3'd0 || bus.tocando !== 1'b0 || bus.mem_addr !== 4'd0) begin
      n_err++;
      $display("FAIL rst_async_imediato: obtido ard=%0d toc=%b addr=%0d esperado 0 0 0", bus.arduino_out, bus.tocando, bus.mem_addr);
    end
    @(negedge clock); reset = 1'b0;
    ativo = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      if (bus.tocando !== 1'b0 || bus.fim !== 1'b0 || bus.arduino_out !== 3'd0) ativo = 1'b1;
    end
    n_comp++;
    if (ativo !== 1'b0) begin
      n_err++; $display("FAIL rst_async_ocioso: obtido %b esperado 0", ativo);
    end
    $display("test_reset_assincrono done");
  endtask

  task automatic test_aleatorio();
    int f, lim;
    for (int it = 0; it < 8; it++) begin
      for (int k = 0; k < 16; k++)
        rom[k] = ($urandom_range(0, 4) == 0) ? 7'($urandom) : 7'(1 << $urandom_range(0, 6));
      lim = $urandom_range(0, 6);
      f = (lim + 1) * P + 1;
      disparar(4'(lim), f + 1, $urandom_range(2, f - 1));
      for (int c = 1; c <= f + 1; c++) begin
        n_comp++;
        if (obs_ard[c] !== nota_esperada(lim, c) || obs_fim[c] !== (c == f) || obs_toc[c] !== (c <= f)) begin
          n_err++;
          $display("FAIL aleatorio it%0d ciclo %0d: obtido ard=%0d fim=%b toc=%b esperado ard=%0d fim=%b toc=%b",
                   it, c, obs_ard[c], obs_fim[c], obs_toc[c], nota_esperada(lim, c), c == f, c <= f);
        end
      end
      n_comp++;
      if (bus.erro_memoria !== erro_esperado(lim)) begin
        n_err++; $display("FAIL aleatorio_erro it%0d: obtido %b esperado %b", it, bus.erro_memoria, erro_esperado(lim));
      end
      $display("test_aleatorio it%0d limite=%0d done", it, lim);
    end
  endtask

  initial begin
    for (int k = 0; k < 16; k++) rom[k] = 7'd0;
    bus.iniciar = 1'b0; bus.abortar = 1'b0; bus.limite = 4'd0;
    test_reset();
    test_sequencia_basica();
    test_limites();
    test_erro_memoria();
    test_abortar();
    test_iniciar_ignorado();
    test_reset_assincrono();
    test_aleatorio();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_comp, n_err);
    $finish;
  end
endmodule
